// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core.
// Produces PC / IF/ID / ID/EX enables and flushes, with a halt/drain/resume
// sequencer and saturating performance counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal issue; load-use / syscall stalls and jb flushes active
// S_DRAIN | front end frozen, bubbles inserted while EX/MEM/WB empty out
// S_HALT  | core parked, halted=1, waits for a resume pulse
module pipe_hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int LOAD_LAT  = 1,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_syscall,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_we,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_we,
  input  logic             mem_mem_read,
  input  logic             jb,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [REG_W-1:0] R_V0 = REG_W'(2);
  localparam logic [REG_W-1:0] R_A0 = REG_W'(4);
  localparam logic             LAT2 = (LOAD_LAT == 2);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          lu_ex, lu_mem, sys_haz, stall;
  logic          drain_first;

  // $0 is hardwired, so a read of it can never depend on an in-flight write
  function automatic logic reg_hit(input logic used, input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return used && (src != '0) && (src == dst);
  endfunction

  // Hazard detection from ID sources against EX/MEM destinations
  always_comb begin
    lu_ex   = ex_mem_read &
              (reg_hit(id_rs_used, id_rs, ex_dst) | reg_hit(id_rt_used, id_rt, ex_dst));
    lu_mem  = LAT2 & mem_mem_read &
              (reg_hit(id_rs_used, id_rs, mem_dst) | reg_hit(id_rt_used, id_rt, mem_dst));
    sys_haz = id_syscall &
              ((ex_we  & ((ex_dst  == R_V0) | (ex_dst  == R_A0))) |
               (mem_we & ((mem_dst == R_V0) | (mem_dst == R_A0))));
    stall   = lu_ex | lu_mem | sys_haz;
    drain_first = (drain_cnt == DRAIN_LOAD);
  end

  // Pipeline controls: combinational from inputs and current state
  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    if_id_clr = 1'b0;
    id_ex_clr = 1'b0;
    if (!rst_n) begin
      // Hold both buffers in flush while reset is asserted
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (jb) begin
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
          end else if (stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
          end
        end
        S_DRAIN: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_clr = 1'b1;
          // A branch resolving as draining starts would leave a wrong-path fetch in IF/ID
          if_id_clr = jb & drain_first;
        end
        default: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_clr = 1'b1;
        end
      endcase
    end
  end

  // Run/drain/halt sequencer with drain down-counter and registered halted flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (halt_req) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: begin
          if (resume) begin
            state  <= S_RUN;
            halted <= 1'b0;
          end
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != S_HALT) && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((state == S_RUN) && stall && !jb && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == S_RUN) && jb && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two instances (LOAD_LAT=1 default config, and LOAD_LAT=2
// with a short drain and narrow counters so saturation is reachable).
module tb_pipe_hazard_ctrl;

  typedef struct {
    bit       rst_n;
    bit [4:0] id_rs, id_rt, ex_dst, mem_dst;
    bit       id_rs_used, id_rt_used, id_syscall;
    bit       ex_we, ex_mem_read, mem_we, mem_mem_read;
    bit       jb, halt_req, resume;
  } in_t;

  typedef struct {
    bit     pc_en, if_id_en, if_id_clr, id_ex_clr, halted;
    longint cyc, stl, fl;
  } exp_t;

  typedef struct {
    int     drain_left;
    bit     halted;
    longint cyc, stl, fl;
  } mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       id_rs_used, id_rt_used, id_syscall;
  logic       ex_we, ex_mem_read, mem_we, mem_mem_read;
  logic       jb, halt_req, resume;

  logic        pc_en0, if_id_en0, if_id_clr0, id_ex_clr0, halted0;
  logic [31:0] cyc0, stl0, fl0;
  logic        pc_en1, if_id_en1, if_id_clr1, id_ex_clr1, halted1;
  logic [5:0]  cyc1, stl1, fl1;

  pipe_hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .DRAIN_CYC(3), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_syscall(id_syscall),
    .ex_dst(ex_dst), .ex_we(ex_we), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_we(mem_we), .mem_mem_read(mem_mem_read),
    .jb(jb), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en0), .if_id_en(if_id_en0), .if_id_clr(if_id_clr0), .id_ex_clr(id_ex_clr0),
    .halted(halted0), .cycle_cnt(cyc0), .stall_cnt(stl0), .flush_cnt(fl0));

  pipe_hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .DRAIN_CYC(2), .CNT_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_syscall(id_syscall),
    .ex_dst(ex_dst), .ex_we(ex_we), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_we(mem_we), .mem_mem_read(mem_mem_read),
    .jb(jb), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_clr(if_id_clr1), .id_ex_clr(id_ex_clr1),
    .halted(halted1), .cycle_cnt(cyc1), .stall_cnt(stl1), .flush_cnt(fl1));

  exp_t q0[$];
  exp_t q1[$];
  mst_t m0, m1;
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;

  function automatic bit hit(bit used, bit [4:0] src, bit [4:0] dst);
    return used && src != 0 && src == dst;
  endfunction

  // Reference model: one clock cycle of behaviour, expressed as
  // "how many drain cycles are left" plus a halted flag.
  task automatic model_step(input int lat, input int dcyc, input int cw,
                            input in_t x, inout mst_t s, output exp_t e);
    longint sat;
    bit     uses_ex, uses_mem, is_load_use, sys, stall;
    sat = (longint'(1) << cw) - 1;
    e.halted = s.halted; e.cyc = s.cyc; e.stl = s.stl; e.fl = s.fl;
    if (!x.rst_n) begin
      e.pc_en = 1; e.if_id_en = 1; e.if_id_clr = 1; e.id_ex_clr = 1;
      s.drain_left = 0; s.halted = 0; s.cyc = 0; s.stl = 0; s.fl = 0;
      return;
    end
    if (s.halted) begin
      e.pc_en = 0; e.if_id_en = 0; e.if_id_clr = 0; e.id_ex_clr = 1;
      if (x.resume) s.halted = 0;
      return;
    end
    if (s.cyc < sat) s.cyc++;
    if (s.drain_left > 0) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_clr = 1;
      e.if_id_clr = x.jb && (s.drain_left == dcyc);
      s.drain_left--;
      if (s.drain_left == 0) s.halted = 1;
      return;
    end
    uses_ex  = hit(x.id_rs_used, x.id_rs, x.ex_dst)  || hit(x.id_rt_used, x.id_rt, x.ex_dst);
    uses_mem = hit(x.id_rs_used, x.id_rs, x.mem_dst) || hit(x.id_rt_used, x.id_rt, x.mem_dst);
    is_load_use = (x.ex_mem_read && uses_ex) || (lat == 2 && x.mem_mem_read && uses_mem);
    sys = x.id_syscall && ((x.ex_we && (x.ex_dst == 2 || x.ex_dst == 4)) ||
                           (x.mem_we && (x.mem_dst == 2 || x.mem_dst == 4)));
    stall = is_load_use || sys;
    if (x.jb) begin
      e.pc_en = 1; e.if_id_en = 1; e.if_id_clr = 1; e.id_ex_clr = 1;
      if (s.fl < sat) s.fl++;
    end else if (stall) begin
      e.pc_en = 0; e.if_id_en = 0; e.if_id_clr = 0; e.id_ex_clr = 1;
      if (s.stl < sat) s.stl++;
    end else begin
      e.pc_en = 1; e.if_id_en = 1; e.if_id_clr = 0; e.id_ex_clr = 0;
    end
    if (x.halt_req) s.drain_left = dcyc;
  endtask

  function automatic in_t idle();
    in_t t;
    t = '{rst_n: 1, default: 0};
    return t;
  endfunction

  task automatic drive(input in_t x);
    exp_t e;
    @(posedge clk); #1;
    rst_n = x.rst_n; id_rs = x.id_rs; id_rt = x.id_rt; ex_dst = x.ex_dst; mem_dst = x.mem_dst;
    id_rs_used = x.id_rs_used; id_rt_used = x.id_rt_used; id_syscall = x.id_syscall;
    ex_we = x.ex_we; ex_mem_read = x.ex_mem_read; mem_we = x.mem_we;
    mem_mem_read = x.mem_mem_read; jb = x.jb; halt_req = x.halt_req; resume = x.resume;
    model_step(1, 3, 32, x, m0, e); q0.push_back(e);
    model_step(2, 2, 6,  x, m1, e); q1.push_back(e);
  endtask

  task automatic chk(input int d, input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL dut%0d %s cycle=%0d got=%0d expected=%0d", d, name, cyc_no, got, want);
    end
  endtask

  // Monitor: every cycle is an output beat; compare at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk(0, "pc_en", pc_en0, e.pc_en);         chk(0, "if_id_en", if_id_en0, e.if_id_en);
        chk(0, "if_id_clr", if_id_clr0, e.if_id_clr); chk(0, "id_ex_clr", id_ex_clr0, e.id_ex_clr);
        chk(0, "halted", halted0, e.halted);      chk(0, "cycle_cnt", longint'(cyc0), e.cyc);
        chk(0, "stall_cnt", longint'(stl0), e.stl); chk(0, "flush_cnt", longint'(fl0), e.fl);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk(1, "pc_en", pc_en1, e.pc_en);         chk(1, "if_id_en", if_id_en1, e.if_id_en);
        chk(1, "if_id_clr", if_id_clr1, e.if_id_clr); chk(1, "id_ex_clr", id_ex_clr1, e.id_ex_clr);
        chk(1, "halted", halted1, e.halted);      chk(1, "cycle_cnt", longint'(cyc1), e.cyc);
        chk(1, "stall_cnt", longint'(stl1), e.stl); chk(1, "flush_cnt", longint'(fl1), e.fl);
      end
      cyc_no++;
    end
  end

  initial begin
    in_t t;
    int  budget;
    m0 = '{default: 0};
    m1 = '{default: 0};
    t = idle();
    rst_n = 0; id_rs = 0; id_rt = 0; ex_dst = 0; mem_dst = 0;
    id_rs_used = 0; id_rt_used = 0; id_syscall = 0; ex_we = 0; ex_mem_read = 0;
    mem_we = 0; mem_mem_read = 0; jb = 0; halt_req = 0; resume = 0;
    repeat (2) @(posedge clk);

    // Reset state, then idle
    t = idle(); t.rst_n = 0; drive(t);
    drive(idle());
    // Load-use in EX
    t = idle(); t.ex_mem_read = 1; t.ex_dst = 5; t.id_rs = 5; t.id_rs_used = 1; drive(t);
    // Same with $0 destination
    t.ex_dst = 0; t.id_rs = 0; drive(t);
    // MEM-stage load: stalls only the LOAD_LAT=2 instance
    t = idle(); t.mem_mem_read = 1; t.mem_dst = 7; t.id_rt = 7; t.id_rt_used = 1; drive(t);
    // Syscall vs in-flight $v0 write, then a harmless $3 write
    t = idle(); t.id_syscall = 1; t.mem_we = 1; t.mem_dst = 2; drive(t);
    t.mem_dst = 3; drive(t);
    t.ex_we = 1; t.ex_dst = 4; t.mem_dst = 3; drive(t);
    // Branch coincident with load-use
    t = idle(); t.jb = 1; t.ex_mem_read = 1; t.ex_dst = 5; t.id_rs = 5; t.id_rs_used = 1; drive(t);
    // Halt with a simultaneous resume, jb in first drain cycle, then park
    t = idle(); t.halt_req = 1; t.resume = 1; drive(t);
    t = idle(); t.jb = 1; drive(t);
    t = idle(); t.jb = 1; t.halt_req = 1; drive(t);
    repeat (4) drive(idle());
    t = idle(); t.resume = 1; drive(t);
    drive(idle());
    // Reset in the middle of draining
    t = idle(); t.halt_req = 1; drive(t);
    drive(idle());
    t = idle(); t.rst_n = 0; drive(t);
    drive(idle());

    // Randomized traffic with indices biased to collide
    for (int i = 0; i < 3000; i++) begin
      t.rst_n        = ($urandom_range(0, 399) != 0);
      t.id_rs        = 5'($urandom_range(0, 7));
      t.id_rt        = 5'($urandom_range(0, 7));
      t.ex_dst       = 5'($urandom_range(0, 7));
      t.mem_dst      = 5'($urandom_range(0, 7));
      t.id_rs_used   = 1'($urandom_range(0, 1));
      t.id_rt_used   = 1'($urandom_range(0, 1));
      t.id_syscall   = ($urandom_range(0, 7) == 0);
      t.ex_we        = 1'($urandom_range(0, 1));
      t.ex_mem_read  = 1'($urandom_range(0, 1));
      t.mem_we       = 1'($urandom_range(0, 1));
      t.mem_mem_read = 1'($urandom_range(0, 1));
      t.jb           = ($urandom_range(0, 5) == 0);
      t.halt_req     = ($urandom_range(0, 29) == 0);
      t.resume       = ($urandom_range(0, 3) == 0);
      drive(t);
    end

    budget = 20;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_queue pending=%0d expected=0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
